// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to unsigned binary converter.
//
// Runs a reverse double-dabble: each clock in CONV shifts the combined
// {bcd, bin} register right by one bit. It then subtracts 3 from every BCD
// digit that reads 8 or more. After 4*DIGITS steps the low half holds the
// binary value.
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST_N in   asynchronous active-low reset
//   START in   conversion request
//   BCD   in   packed BCD operand [4*DIGITS-1:0], sampled when START is accepted
//   BIN   out  binary result, held until the next completion
//   BUSY  out  conversion in progress
//   DONE  out  one-cycle completion pulse (valid result or error)
//   ERR   out  operand contained a nibble > 9, held until the next completion
module bcd_to_bin #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic [4*DIGITS-1:0]   BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] LastStep = CntW'(W - 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e            state_q, state_d;
  logic [2*W-1:0]    sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      bin_q, bin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  // A rejected operand reports one edge after it is sampled.
  logic              err_pend_q, err_pend_d;

  logic              bcd_ok;
  logic [2*W-1:0]    sr_step;

  // Operand check: every nibble must be a decimal digit.
  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (BCD[4*i +: 4] > 4'd9) begin
        bcd_ok = 1'b0;
      end
    end
  end

  // One shift-and-correct step. The correction applies to the BCD half
  // only, after the shift. All digits are corrected in parallel.
  always_comb begin
    sr_step = sr_q >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_step[int'(W) + 4*i +: 4] >= 4'd8) begin
        sr_step[int'(W) + 4*i +: 4] = sr_step[int'(W) + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_pend_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (err_pend_q) begin
          // START is not taken here, so BUSY never rises while DONE is high.
          done_d = 1'b1;
          err_d  = 1'b1;
          bin_d  = '0;
        end else if (START) begin
          if (bcd_ok) begin
            sr_d    = {BCD, {W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = StConv;
          end else begin
            err_pend_d = 1'b1;
          end
        end
      end

      StConv: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) begin
          bin_d   = sr_step[W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      bin_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign BIN  = bin_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Testbench for bcd_to_bin with a 2-digit and a 3-digit instance.
module tb_bcd_to_bin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start2, busy2, done2, err2;
  logic [7:0]  bcd2, bin2;
  logic        start3, busy3, done3, err3;
  logic [11:0] bcd3, bin3;

  bcd_to_bin #(.DIGITS(2)) u_dut2 (
    .CLK  (clk),
    .RST_N(rst_n),
    .START(start2),
    .BCD  (bcd2),
    .BIN  (bin2),
    .BUSY (busy2),
    .DONE (done2),
    .ERR  (err2)
  );

  bcd_to_bin #(.DIGITS(3)) u_dut3 (
    .CLK  (clk),
    .RST_N(rst_n),
    .START(start3),
    .BCD  (bcd3),
    .BIN  (bin3),
    .BUSY (busy3),
    .DONE (done3),
    .ERR  (err3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 2;

  logic [15:0] cur_bin;
  logic        cur_busy, cur_done, cur_err;

  always_comb begin
    if (sel == 3) begin
      cur_bin  = {4'h0, bin3};
      cur_busy = busy3;
      cur_done = done3;
      cur_err  = err3;
    end else begin
      cur_bin  = {8'h00, bin2};
      cur_busy = busy2;
      cur_done = done2;
      cur_err  = err2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Called at 1 time unit after a rising edge; returns at the same phase on the DONE cycle.
  task automatic run(input int d, input logic [15:0] bcd, input logic [15:0] exp_bin,
                     input bit exp_err, input string tag);
    int lat;
    sel = d;
    if (d == 3) begin
      start3 = 1'b1;
      bcd3   = bcd[11:0];
    end else begin
      start2 = 1'b1;
      bcd2   = bcd[7:0];
    end
    @(posedge clk); #1;
    start2 = 1'b0;
    start3 = 1'b0;
    check({tag, " busy after accept"}, 32'(cur_busy), 32'(!exp_err));
    lat = 0;
    while (!cur_done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_err ? 1 : 4 * d);
    check({tag, " busy low with done"}, 32'(cur_busy), 0);
    check({tag, " bin"}, 32'(cur_bin), 32'(exp_bin));
    check({tag, " err"}, 32'(cur_err), 32'(exp_err));
  endtask

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    bcd2   = '0;
    bcd3   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset bin2", 32'(bin2), 0);
    check("reset busy2", 32'(busy2), 0);
    check("reset done2", 32'(done2), 0);
    check("reset err2", 32'(err2), 0);
    check("reset bin3", 32'(bin3), 0);
    check("reset busy3", 32'(busy3), 0);
    rst_n = 1'b1;

    // First START right after reset release.
    run(2, 16'h0031, 16'h001F, 1'b0, "bcd31");
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("bcd31 bin held", 32'(bin2), 32'h1F);
    check("bcd31 done single pulse", 32'(done2), 0);

    // Back-to-back sweep of all valid 2-digit codes.
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        run(2, {8'h00, 4'(t), 4'(o)}, 16'(t * 10 + o), 1'b0, "sweep");
      end
    end

    // Invalid operand, then a valid one started on the error DONE cycle.
    run(2, 16'h003A, 16'h0000, 1'b1, "bcd3A");
    run(2, 16'h0042, 16'd42, 1'b0, "bcd42");

    // START re-pulsed during CONV must be ignored.
    sel    = 2;
    start2 = 1'b1;
    bcd2   = 8'h99;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    start2 = 1'b1;
    bcd2   = 8'h11;
    @(posedge clk); #1;
    start2 = 1'b0;
    ndone  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done2) ndone++;
    end
    check("ignore start done count", ndone, 1);
    check("ignore start bin", 32'(bin2), 32'h63);
    check("ignore start err", 32'(err2), 0);

    // Reset mid-conversion.
    start2 = 1'b1;
    bcd2   = 8'h77;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort bin", 32'(bin2), 0);
    check("abort busy", 32'(busy2), 0);
    check("abort done", 32'(done2), 0);
    check("abort err", 32'(err2), 0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done2) ndone++;
    end
    check("abort no done", ndone, 0);
    rst_n = 1'b1;
    run(2, 16'h0005, 16'd5, 1'b0, "post-reset bcd05");

    // Three-digit instance.
    run(3, 16'h0255, 16'h00FF, 1'b0, "d3 bcd255");
    run(3, 16'h0999, 16'h03E7, 1'b0, "d3 bcd999");
    run(3, 16'h01A3, 16'h0000, 1'b1, "d3 bcd1A3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
